booth2_mult4u: RTL and testbench
================================

Name: booth2_mult4u

Overview:
- Sequential 4x4 unsigned multiplier using radix-4 (Booth-2) recoding.
- Free-running: it repeatedly samples its operands, computes the product over several clock cycles, and publishes it on a registered 9-bit result.
- It is a leaf arithmetic block. There is no start/ready handshake; consumers hold the operands stable for at least one full compute cycle (6 clocks).

Parameters:
- W, 4, operand width. Only the value 4 is supported; it exists to size internal buses.
- RW, 9, result width (2*W+1). Bit RW-1 is always 0 for unsigned operands.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- x  input  4  multiplicand, unsigned
- multiplier  input  4  multiplier, unsigned
- result  output  9  registered product x*multiplier, zero-extended

Behaviour:
- Reset: rst==0 at a posedge forces state=LOAD, result=0, and all internal registers to 0. Reset overrides everything; asserting it mid-compute aborts the current compute without updating result.
- FSM states are LOAD, CALC0, CALC1, CALC2, DONE. The sequence is strictly LOAD->CALC0->CALC1->CALC2->DONE->LOAD, one clock per state.
- LOAD:
  - Capture mcand=x.
  - Capture ybits={2'b00, multiplier, 1'b0} (7 bits; bit 0 is the implicit y[-1]=0).
  - Clear the accumulator acc (11-bit two's complement).
- CALCi (i=0..2):
  - Recode the triple t=ybits[2i+2:2i] to a digit d: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
  - Compute pp = d*mcand, sign-extended to 11 bits. +2/-2 use a left shift of mcand; negatives use two's complement.
  - Update acc <= acc + (pp << 2i).
- Digit 2 sees triple {0,0,m3}, so it is only ever 0 or +1.
- DONE: result <= acc[8:0]. acc[10:9] is always 0, and so is result[8].
- Latency: operands sampled in LOAD appear on result 4 clocks later, at the DONE edge. The result update period is 5 clocks.
- result holds its value between DONE updates.
- Operand changes outside LOAD are ignored until the next LOAD.
- Boundaries:
  - x=0 or multiplier=0 gives 0.
  - 15*15=225 (0x0E1) is the maximum.
  - No overflow is possible with the 11-bit accumulator.

Optional Feature:
- Macro BOOTH2_DONE_EN.
- When defined: adds output port done (1 bit). done is registered and pulses high for exactly one clock, coincident with the cycle in which result first shows a new value (the cycle after the DONE edge). done is 0 in reset.
- When undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Package booth2_pkg holds:
  - the state enum (LOAD, CALC0, CALC1, CALC2, DONE)
  - the width constants W=4, RW=9, AW=11
  - the digit encoding typedef (3-bit signed, -2..+2)
- One sub-module: booth2_recoder.
  - Combinational.
  - Inputs: triple[2:0] and mcand[3:0].
  - Output: pp[10:0], the signed partial product before the positional shift.
- The top holds the FSM, operand registers, accumulator and result register.

Test Plan:
- Reset: hold rst=0 for 3 clocks with x=4'hF, multiplier=4'hF -> result==0 throughout. Release rst -> first update after 5 clocks equals 225 (0x0E1).
- x=12 (1100), multiplier=5 (0101), held >=6 clocks -> result==60 (0x03C), result[8]==0.
- x=9 (1001), multiplier=8 (1000) -> result==72 (0x048). This exercises digit -2 at position 1 and +1 at position 2.
- x=15, multiplier=15 -> result==225 (0x0E1). Then x=0, multiplier=7 -> result==0 (0x000).
- Mid-compute change: change x from 3 to 10 one clock after LOAD with multiplier=6 -> the next update is 18 (0x012) and the following update is 60 (0x03C). Asserting rst during CALC1 -> result==0 and the FSM returns to LOAD.
- Exhaustive sweep: all 256 (x, multiplier) pairs, each held 6 clocks -> result==x*multiplier. With BOOTH2_DONE_EN defined, exactly one done pulse per 5 clocks.

Source files
------------

// File: rtl/booth2_pkg.sv
// Shared types and widths for the radix-4 Booth 4x4 unsigned multiplier.
package booth2_pkg;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W + 1;
  localparam int unsigned AW = 2 * W + 3;
  localparam int unsigned YW = W + 3;

  typedef enum logic [2:0] {
    LOAD,
    CALC0,
    CALC1,
    CALC2,
    DONE
  } state_t;

  // Booth-2 digit, range -2..+2
  typedef logic signed [2:0] digit_t;

  localparam digit_t DIG_ZERO = 3'sb000;
  localparam digit_t DIG_P1   = 3'sb001;
  localparam digit_t DIG_P2   = 3'sb010;
  localparam digit_t DIG_M1   = 3'sb111;
  localparam digit_t DIG_M2   = 3'sb110;

endpackage

// File: rtl/booth2_recoder.sv
// Combinational Booth-2 recoder: maps a multiplier bit triple to the signed
// partial product digit*mcand, sign-extended to the accumulator width.
module booth2_recoder
  import booth2_pkg::*;
(
  input  logic [2:0]    triple,
  input  logic [W-1:0]  mcand,
  output logic [AW-1:0] pp
);

  digit_t        digit;
  logic [AW-1:0] ext;

  assign ext = AW'(mcand);

  // Triple to digit
  always_comb begin
    digit = DIG_ZERO;
    unique case (triple)
      3'b001, 3'b010: digit = DIG_P1;
      3'b011:         digit = DIG_P2;
      3'b100:         digit = DIG_M2;
      3'b101, 3'b110: digit = DIG_M1;
      default:        digit = DIG_ZERO;
    endcase
  end

  // Digit times multiplicand; negatives via two's complement
  always_comb begin
    pp = '0;
    unique case (digit)
      DIG_P1:  pp = ext;
      DIG_P2:  pp = ext << 1;
      DIG_M1:  pp = (~ext) + AW'(1);
      DIG_M2:  pp = (~(ext << 1)) + AW'(1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth2_mult4u.sv
// Free-running sequential 4x4 unsigned Booth-2 multiplier, 5-clock result period.
// Optional BOOTH2_DONE_EN adds a one-clock done pulse when result refreshes.
module booth2_mult4u
  import booth2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  multiplier,
  output logic [RW-1:0] result
`ifdef BOOTH2_DONE_EN
  ,
  output logic          done
`endif
);

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  mcand;
  logic [YW-1:0] ybits;
  logic [AW-1:0] acc;
  logic [2:0]    triple;
  logic [AW-1:0] pp;
  logic [AW-1:0] pp_sh;

  booth2_recoder u_recoder (
    .triple (triple),
    .mcand  (mcand),
    .pp     (pp)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state and triple selection
  always_comb begin
    state_next = state;
    triple     = 3'b000;
    unique case (state)
      LOAD: begin
        state_next = CALC0;
      end
      CALC0: begin
        state_next = CALC1;
        triple     = ybits[2:0];
      end
      CALC1: begin
        state_next = CALC2;
        triple     = ybits[4:2];
      end
      CALC2: begin
        state_next = DONE;
        triple     = ybits[6:4];
      end
      DONE: begin
        state_next = LOAD;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Positional weight 4^i of the current partial product
  always_comb begin
    pp_sh = pp;
    unique case (state)
      CALC1:   pp_sh = pp << 2;
      CALC2:   pp_sh = pp << 4;
      default: pp_sh = pp;
    endcase
  end

  // Operand capture, accumulation and result publication
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      ybits  <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          mcand <= x;
          ybits <= {2'b00, multiplier, 1'b0};
          acc   <= '0;
        end
        CALC0, CALC1, CALC2: begin
          acc <= acc + pp_sh;
        end
        DONE: begin
          result <= acc[RW-1:0];
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BOOTH2_DONE_EN
  // High for the single cycle in which a freshly published result is visible
  always_ff @(posedge clk) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end
`endif

endmodule

// File: tb/tb_booth2_mult4u.sv
// Self-checking bench for booth2_mult4u against a plain a*b product model.
module tb_booth2_mult4u;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] x = 4'h0;
  logic [3:0] multiplier = 4'h0;
  logic [8:0] result;
  logic       done;

  int         checks = 0;
  int         passed = 0;
  logic [8:0] held = 9'h000;

  always #5 clk = ~clk;

  booth2_mult4u dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .multiplier (multiplier),
    .result     (result)
`ifdef BOOTH2_DONE_EN
    ,
    .done       (done)
`endif
  );

`ifndef BOOTH2_DONE_EN
  assign done = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 5-clock compute window: operands presented before the LOAD edge,
  // optionally changing x one clock after LOAD, product expected at edge 5.
  task automatic run_window(input int a, input int b, input bit chg, input int a2,
                            input string tag);
    logic [8:0] expv;
    expv = 9'(a * b);
    x = 4'(a);
    multiplier = 4'(b);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1 && chg) x = 4'(a2);
      checks++;
      if (e < 5) begin
        if (result !== held)
          $display("FAIL %s hold e=%0d a=%0d b=%0d result=%h required=%h", tag, e, a, b, result, held);
        else passed++;
      end else begin
        if (result !== expv)
          $display("FAIL %s product a=%0d b=%0d result=%h required=%h", tag, a, b, result, expv);
        else passed++;
      end
`ifdef BOOTH2_DONE_EN
      checks++;
      if (done !== (e == 5))
        $display("FAIL %s done e=%0d done=%b required=%b", tag, e, done, (e == 5));
      else passed++;
`endif
    end
    held = expv;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    x = 4'hF;
    multiplier = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (result !== 9'h000 || done !== 1'b0)
        $display("FAIL reset_hold result=%h done=%b required=000/0", result, done);
      else passed++;
    end
    rst = 1'b1;
    held = 9'h000;
    run_window(15, 15, 1'b0, 0, "reset_first");
  endtask

  task automatic test_directed();
    run_window(12, 5, 1'b0, 0, "dir_12x5");
    checks++;
    if (result[8] !== 1'b0)
      $display("FAIL msb result8=%b required=0", result[8]);
    else passed++;
    run_window(9, 8, 1'b0, 0, "dir_9x8");
    run_window(15, 15, 1'b0, 0, "dir_max");
    run_window(0, 7, 1'b0, 0, "dir_zero_x");
    run_window(11, 0, 1'b0, 0, "dir_zero_m");
  endtask

  task automatic test_mid_change();
    run_window(3, 6, 1'b1, 10, "mid_change");
    run_window(10, 6, 1'b0, 0, "mid_follow");
  endtask

  task automatic test_reset_mid();
    run_window(7, 7, 1'b0, 0, "pre_abort");
    x = 4'd5;
    multiplier = 4'd5;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (result !== 9'h000 || done !== 1'b0)
      $display("FAIL abort_reset result=%h done=%b required=000/0", result, done);
    else passed++;
    held = 9'h000;
    run_window(13, 11, 1'b0, 0, "post_abort");
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_window(a, b, 1'b0, 0, "sweep");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int a, b, a2;
      bit chg;
      a = int'($urandom_range(15));
      b = int'($urandom_range(15));
      a2 = int'($urandom_range(15));
      chg = 1'($urandom_range(1));
      run_window(a, b, chg, a2, "random");
      if (chg) x = 4'(a);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_change();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
